// File: rtl/addr_scan_seq.sv
// Address scan sequencer feeding the 4-to-16 decoder: walks enabled addresses with a programmable dwell.
// Optional HOLD input (freezes the dwell) is enabled by defining ADDR_SCAN_SEQ_HOLD_EN.
module addr_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ADDR_SCAN_SEQ_HOLD_EN
  input  logic               hold,
`endif
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic [3:0]         addr,
  output logic               valid,
  output logic               step,
  output logic               done,
  output logic               busy
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state, state_d;
  logic [3:0]         addr_d;
  logic               valid_d, step_d, done_d, busy_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic               mode_q, mode_d, dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] load_val, reload_val;
  logic [5:0]         first_res, next_res;
  logic               hold_act;

  // Nearest enabled address strictly after cur in direction d; offset 16 lands back on cur.
  // Result is {found, wrapped, address}; wrapped is set when the search crossed the 15/0 end.
  function automatic logic [5:0] find_next(input logic [3:0] cur, input logic d,
                                           input logic [15:0] m);
    logic       found, wrapped;
    logic [3:0] nxt;
    logic [4:0] idx;
    found   = 1'b0;
    wrapped = 1'b0;
    nxt     = cur;
    for (int k = 1; k <= 16; k++) begin
      idx = d ? ({1'b0, cur} - 5'(k)) : ({1'b0, cur} + 5'(k));
      if (!found && m[idx[3:0]]) begin
        found   = 1'b1;
        wrapped = idx[4];
        nxt     = idx[3:0];
      end
    end
    return {found, wrapped, nxt};
  endfunction

`ifdef ADDR_SCAN_SEQ_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  assign load_val   = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign reload_val = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  // Inclusive search from 0 (or 15) is a strict search starting one position before it.
  assign first_res  = find_next(dir ? 4'd0 : 4'd15, dir, mask);
  assign next_res   = find_next(addr, dir_q, mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      valid   <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      valid   <= valid_d;
      step    <= step_d;
      done    <= done_d;
      busy    <= busy_d;
      cnt     <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr;
    valid_d = valid;
    step_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy;
    cnt_d   = cnt;
    mode_d  = mode_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    if (stop) begin
      state_d = IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_d  = mode_cont;
            dir_d   = dir;
            dwell_d = dwell;
            if (first_res[5]) begin
              addr_d  = first_res[3:0];
              valid_d = 1'b1;
              busy_d  = 1'b1;
              step_d  = 1'b1;
              cnt_d   = load_val;
              state_d = DWELL;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        DWELL: begin
          if (hold_act) begin
            cnt_d = cnt;
          end else if (cnt > DWELL_W'(1)) begin
            cnt_d = cnt - DWELL_W'(1);
          end else if (!next_res[5] || (next_res[4] && !mode_q)) begin
            done_d  = 1'b1;
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            // A wrapped advance in continuous mode marks the pass boundary too.
            done_d = next_res[4];
            step_d = 1'b1;
            addr_d = next_res[3:0];
            cnt_d  = reload_val;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_scan_seq.sv
// Directed self-checking bench for addr_scan_seq; define ADDR_SCAN_SEQ_HOLD_EN to also exercise HOLD.
module tb_addr_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode_cont, dir;
  logic [7:0]  dwell;
  logic [15:0] mask;
  logic [3:0]  addr;
  logic        valid, step, done, busy;
`ifdef ADDR_SCAN_SEQ_HOLD_EN
  logic        hold = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  addr_scan_seq #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ADDR_SCAN_SEQ_HOLD_EN
    .hold      (hold),
`endif
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .dir       (dir),
    .dwell     (dwell),
    .mask      (mask),
    .addr      (addr),
    .valid     (valid),
    .step      (step),
    .done      (done),
    .busy      (busy)
  );

  task automatic applyStimulus(input logic st, input logic sp, input logic mc, input logic d,
                               input logic [7:0] dw, input logic [15:0] m);
    start     = st;
    stop      = sp;
    mode_cont = mc;
    dir       = d;
    dwell     = dw;
    mask      = m;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkField(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ea, input logic ev,
                             input logic es, input logic ed, input logic eb);
    checkField({tag, ".addr"},  16'(addr),  16'(ea));
    checkField({tag, ".valid"}, 16'(valid), 16'(ev));
    checkField({tag, ".step"},  16'(step),  16'(es));
    checkField({tag, ".done"},  16'(done),  16'(ed));
    checkField({tag, ".busy"},  16'(busy),  16'(eb));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'd0, 16'h0000);
    @(negedge clk);
    checkOutput("reset", 4'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    checkOutput("idle", 4'd0, 0, 0, 0, 0);

    // Full ascending single pass, dwell 3.
    applyStimulus(1, 0, 0, 0, 8'd3, 16'hFFFF);
    cyc();
    applyStimulus(0, 0, 0, 0, 8'd3, 16'hFFFF);
    for (int a = 0; a < 16; a++) begin
      for (int c = 0; c < 3; c++) begin
        if (a != 0 || c != 0) cyc();
        checkOutput($sformatf("asc_a%0d_c%0d", a, c), 4'(a), 1, (c == 0), 0, 1);
      end
    end
    cyc();
    checkOutput("asc_done", 4'd15, 0, 0, 1, 0);
    cyc();
    checkOutput("asc_after", 4'd15, 0, 0, 0, 0);

    // Masked descending pass, dwell 0 behaves as 1.
    applyStimulus(1, 0, 0, 1, 8'd0, 16'h8421);
    cyc();
    applyStimulus(0, 0, 0, 1, 8'd0, 16'h8421);
    checkOutput("desc_15", 4'd15, 1, 1, 0, 1);
    cyc();
    checkOutput("desc_10", 4'd10, 1, 1, 0, 1);
    cyc();
    checkOutput("desc_5", 4'd5, 1, 1, 0, 1);
    cyc();
    checkOutput("desc_0", 4'd0, 1, 1, 0, 1);
    cyc();
    checkOutput("desc_done", 4'd0, 0, 0, 1, 0);

    // Continuous scan of a single address, then STOP.
    applyStimulus(1, 0, 1, 0, 8'd2, 16'h0010);
    cyc();
    applyStimulus(0, 0, 1, 0, 8'd2, 16'h0010);
    checkOutput("cont_first", 4'd4, 1, 1, 0, 1);
    cyc();
    checkOutput("cont_hold1", 4'd4, 1, 0, 0, 1);
    cyc();
    checkOutput("cont_wrap1", 4'd4, 1, 1, 1, 1);
    cyc();
    checkOutput("cont_hold2", 4'd4, 1, 0, 0, 1);
    cyc();
    checkOutput("cont_wrap2", 4'd4, 1, 1, 1, 1);
    applyStimulus(0, 1, 1, 0, 8'd2, 16'h0010);
    cyc();
    checkOutput("cont_stop", 4'd4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 8'd2, 16'h0010);
    cyc();
    checkOutput("cont_after_stop", 4'd4, 0, 0, 0, 0);

    // START with an empty mask.
    applyStimulus(1, 0, 0, 0, 8'd2, 16'h0000);
    cyc();
    applyStimulus(0, 0, 0, 0, 8'd2, 16'h0000);
    checkOutput("empty_done", 4'd4, 0, 0, 1, 0);
    cyc();
    checkOutput("empty_after", 4'd4, 0, 0, 0, 0);

    // START together with STOP.
    applyStimulus(1, 1, 0, 0, 8'd2, 16'hFFFF);
    cyc();
    applyStimulus(0, 0, 0, 0, 8'd2, 16'hFFFF);
    checkOutput("startstop", 4'd4, 0, 0, 0, 0);

    // START while busy must not change latched dir/dwell.
    applyStimulus(1, 0, 0, 0, 8'd2, 16'h0006);
    cyc();
    applyStimulus(1, 0, 1, 1, 8'd5, 16'h0006);
    checkOutput("busy_a1", 4'd1, 1, 1, 0, 1);
    cyc();
    checkOutput("busy_a1b", 4'd1, 1, 0, 0, 1);
    cyc();
    checkOutput("busy_a2", 4'd2, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 8'd5, 16'h0006);
    cyc();
    checkOutput("busy_a2b", 4'd2, 1, 0, 0, 1);
    cyc();
    checkOutput("busy_done", 4'd2, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a scan.
    applyStimulus(1, 0, 0, 0, 8'd1, 16'hFFFF);
    cyc();
    applyStimulus(0, 0, 0, 0, 8'd1, 16'hFFFF);
    for (int i = 0; i < 7; i++) cyc();
    checkOutput("pre_reset", 4'd7, 1, 1, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checkOutput("post_reset", 4'd0, 0, 0, 0, 0);

`ifdef ADDR_SCAN_SEQ_HOLD_EN
    // HOLD for 5 cycles stretches a 4-cycle dwell to 9.
    applyStimulus(1, 0, 0, 0, 8'd4, 16'hFFFF);
    cyc();
    applyStimulus(0, 0, 0, 0, 8'd4, 16'hFFFF);
    checkOutput("hold_start", 4'd0, 1, 1, 0, 1);
    cyc();
    checkOutput("hold_pre", 4'd0, 1, 0, 0, 1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checkOutput($sformatf("hold_%0d", i), 4'd0, 1, 0, 0, 1);
    end
    hold = 1'b0;
    cyc();
    checkOutput("hold_post1", 4'd0, 1, 0, 0, 1);
    cyc();
    checkOutput("hold_post2", 4'd0, 1, 0, 0, 1);
    cyc();
    checkOutput("hold_adv", 4'd1, 1, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 8'd4, 16'hFFFF);
    cyc();
    checkOutput("hold_stop", 4'd1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 8'd4, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
